// File: rtl/css_mcu0_el2_ghr_tracker.sv
// Purpose: speculative/retired global branch history tracker with a checkpoint FIFO for misprediction recovery.
// Latency: all outputs registered; every update is visible one cycle after the triggering edge.
// Backpressure: pred_ready drops when all CKPT_DEPTH checkpoints are in flight; a prediction offered then is dropped without side effects.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   pred_valid/pred_taken         - fetch-side conditional branch prediction
//   pred_ready                    - a checkpoint slot is free
//   res_valid/res_taken           - in-order resolution of the oldest in-flight branch
//   res_mispredict                - resolved direction differs from the prediction
//   flush                         - non-branch pipeline flush
//   ghr / ghr_ret                 - speculative / retired history, newest outcome in bit 0
//   ckpt_count                    - occupied checkpoints
//   res_underflow                 - one-cycle pulse after a resolve with no branch in flight
module css_mcu0_el2_ghr_tracker #(
  parameter int GHR_SIZE   = 8,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pred_valid,
  input  logic                          pred_taken,
  output logic                          pred_ready,
  input  logic                          res_valid,
  input  logic                          res_taken,
  input  logic                          res_mispredict,
  input  logic                          flush,
  output logic [GHR_SIZE-1:0]           ghr,
  output logic [GHR_SIZE-1:0]           ghr_ret,
  output logic [$clog2(CKPT_DEPTH):0]   ckpt_count,
  output logic                          res_underflow
);

  localparam int PW = $clog2(CKPT_DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [GHR_SIZE-1:0] shift_hist(input logic [GHR_SIZE-1:0] h,
                                                     input logic                b);
    return {h[GHR_SIZE-2:0], b};
  endfunction

  logic [GHR_SIZE-1:0] ckpt_mem [CKPT_DEPTH];

  logic [GHR_SIZE-1:0] ghr_q, ghr_d;
  logic [GHR_SIZE-1:0] ghr_ret_q, ghr_ret_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                underflow_q, underflow_d;

  logic res_ok;
  logic mispred;
  logic pred_acc;

  // Ready comes from the registered count only, so an entry freed by a
  // same-cycle resolve cannot be reused until the next cycle.
  assign pred_ready = (count_q != CW'(CKPT_DEPTH));

  always_comb begin
    res_ok      = res_valid && (count_q != '0);
    mispred     = res_ok && res_mispredict;
    // A recovery (mispredict or flush) discards the younger path, which
    // includes any branch fetched in the same cycle.
    pred_acc    = pred_valid && pred_ready && !flush && !mispred;
    underflow_d = res_valid && (count_q == '0);

    ghr_ret_d = ghr_ret_q;
    if (res_ok) begin
      ghr_ret_d = shift_hist(ghr_ret_q, res_taken);
    end

    ghr_d   = ghr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      // Flush restarts from retired history including this cycle's resolve,
      // which also covers a simultaneous mispredict.
      ghr_d   = ghr_ret_d;
      head_d  = tail_q;
      count_d = '0;
    end else if (mispred) begin
      ghr_d   = shift_hist(ckpt_mem[head_q], res_taken);
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (pred_acc) begin
        ghr_d  = shift_hist(ghr_q, pred_taken);
        tail_d = tail_q + PW'(1);
      end
      if (res_ok) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(pred_acc) - CW'(res_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q       <= '0;
      ghr_ret_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      ghr_q       <= ghr_d;
      ghr_ret_q   <= ghr_ret_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Checkpoint storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    if (!rst && pred_acc) begin
      ckpt_mem[tail_q] <= ghr_q;
    end
  end

  assign ghr           = ghr_q;
  assign ghr_ret       = ghr_ret_q;
  assign ckpt_count    = count_q;
  assign res_underflow = underflow_q;

endmodule

// File: tb/tb_css_mcu0_el2_ghr_tracker.sv
// Purpose: self-checking bench for css_mcu0_el2_ghr_tracker (GHR_SIZE=8, CKPT_DEPTH=4).
// Latency: a queue-based history model is checked every cycle; literal checks pin key scenarios.
// Backpressure: exercises full-FIFO prediction drop and same-cycle predict/resolve.
module tb_css_mcu0_el2_ghr_tracker;

  localparam int GS = 8;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pred_valid = 1'b0, pred_taken = 1'b0;
  logic          res_valid = 1'b0, res_taken = 1'b0, res_mispredict = 1'b0;
  logic          flush = 1'b0;
  logic          pred_ready;
  logic [GS-1:0] ghr, ghr_ret;
  logic [2:0]    ckpt_count;
  logic          res_underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  css_mcu0_el2_ghr_tracker #(.GHR_SIZE(GS), .CKPT_DEPTH(CD)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .flush(flush),
    .ghr(ghr), .ghr_ret(ghr_ret), .ckpt_count(ckpt_count), .res_underflow(res_underflow)
  );

  // Reference model: history as plain shift arithmetic, checkpoints as a queue.
  logic [GS-1:0] m_ghr, m_ret;
  logic [GS-1:0] m_q[$];
  bit            m_uf;
  bit            m_known = 0;

  function automatic logic [GS-1:0] sh(input logic [GS-1:0] h, input logic b);
    return (h << 1) | GS'(b);
  endfunction

  always @(posedge clk) begin
    logic [GS-1:0] nxt_ghr, nxt_ret, ck;
    bit            mis;
    if (rst) begin
      m_ghr = '0; m_ret = '0; m_q.delete(); m_uf = 0; m_known = 1;
    end else if (m_known) begin
      bit can_pred;
      can_pred = (m_q.size() < CD);
      nxt_ghr = m_ghr;
      nxt_ret = m_ret;
      mis = 0;
      m_uf = res_valid && (m_q.size() == 0);
      if (res_valid && m_q.size() > 0) begin
        ck = m_q.pop_front();
        nxt_ret = sh(m_ret, res_taken);
        if (res_mispredict) begin
          mis = 1;
          nxt_ghr = sh(ck, res_taken);
          m_q.delete();
        end
      end
      if (flush) begin
        nxt_ghr = nxt_ret;
        m_q.delete();
      end else if (!mis && pred_valid && can_pred) begin
        m_q.push_back(m_ghr);
        nxt_ghr = sh(m_ghr, pred_taken);
      end
      m_ghr = nxt_ghr;
      m_ret = nxt_ret;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known && !rst) begin
      chk("cyc_ghr",       int'(ghr),           int'(m_ghr));
      chk("cyc_ghr_ret",   int'(ghr_ret),       int'(m_ret));
      chk("cyc_count",     int'(ckpt_count),    m_q.size());
      chk("cyc_ready",     int'(pred_ready),    int'(m_q.size() < CD));
      chk("cyc_underflow", int'(res_underflow), int'(m_uf));
    end
  end

  // One cycle of stimulus; on return outputs reflect that edge.
  task automatic cyc(input logic pv, input logic pt, input logic rv, input logic rt,
                     input logic rm, input logic fl, input logic rs);
    pred_valid = pv; pred_taken = pt;
    res_valid = rv; res_taken = rt; res_mispredict = rm;
    flush = fl; rst = rs;
    @(posedge clk);
    #1;
    pred_valid = 0; pred_taken = 0; res_valid = 0; res_taken = 0;
    res_mispredict = 0; flush = 0; rst = 0;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic predict_tntt();
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    chk("rst_ghr",   int'(ghr), 0);
    chk("rst_ret",   int'(ghr_ret), 0);
    chk("rst_count", int'(ckpt_count), 0);
    chk("rst_ready", int'(pred_ready), 1);
    chk("rst_uf",    int'(res_underflow), 0);

    // Four predictions fill the FIFO.
    predict_tntt();
    chk("fill_ghr",   int'(ghr), 8'h0B);
    chk("fill_count", int'(ckpt_count), 4);
    chk("fill_ready", int'(pred_ready), 0);

    // Prediction offered while full is dropped.
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("full_ghr",   int'(ghr), 8'h0B);
    chk("full_count", int'(ckpt_count), 4);

    // Correctly predicted resolve retires one branch.
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("res_ret",   int'(ghr_ret), 8'h01);
    chk("res_count", int'(ckpt_count), 3);
    chk("res_ghr",   int'(ghr), 8'h0B);

    // Mispredict at head recovers from checkpoint 00; same-cycle prediction ignored.
    do_reset();
    predict_tntt();
    cyc(1, 1, 1, 0, 1, 0, 0);
    chk("mis_ghr",   int'(ghr), 8'h00);
    chk("mis_ret",   int'(ghr_ret), 8'h00);
    chk("mis_count", int'(ckpt_count), 0);
    chk("mis_ready", int'(pred_ready), 1);

    // Retired history 03, two in flight, flush with a same-cycle taken resolve.
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("pre_ret", int'(ghr_ret), 8'h03);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("pre_ghr", int'(ghr), 8'h0C);
    cyc(1, 1, 1, 1, 1, 1, 0);
    chk("flush_ghr",   int'(ghr), 8'h07);
    chk("flush_ret",   int'(ghr_ret), 8'h07);
    chk("flush_count", int'(ckpt_count), 0);

    // Resolve with nothing in flight: one-cycle underflow pulse, state held.
    cyc(0, 0, 1, 1, 1, 0, 0);
    chk("uf_pulse", int'(res_underflow), 1);
    chk("uf_ghr",   int'(ghr), 8'h07);
    chk("uf_ret",   int'(ghr_ret), 8'h07);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("uf_clear", int'(res_underflow), 0);

    // Mispredict without res_valid is ignored.
    cyc(1, 1, 0, 0, 1, 0, 0);
    chk("stray_mis_count", int'(ckpt_count), 1);
    chk("stray_mis_ghr",   int'(ghr), 8'h0F);

    // Ten predict/resolve cycles wrap the pointers several times.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic rt;
      rt = ((i - 2) % 3 == 0);
      cyc(1, logic'(i % 3 == 0), logic'(i >= 2), (i >= 2) ? rt : 1'b0, 0, 0, 0);
    end
    chk("wrap_ghr",   int'(ghr), 8'h49);
    chk("wrap_ret",   int'(ghr_ret), 8'h92);
    chk("wrap_count", int'(ckpt_count), 2);

    // Reset mid-stream overrides everything else in that cycle.
    cyc(1, 1, 1, 1, 1, 1, 1);
    chk("mid_rst_ghr",   int'(ghr), 0);
    chk("mid_rst_ret",   int'(ghr_ret), 0);
    chk("mid_rst_count", int'(ckpt_count), 0);
    chk("mid_rst_ready", int'(pred_ready), 1);
    chk("mid_rst_uf",    int'(res_underflow), 0);

    cyc(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
